dht11_reader: RTL and testbench
===============================

// Module: dht11_reader
// PURPOSE
//  Single-wire DHT11 protocol engine sitting directly downstream of conexao_sensor.
//  On a start pulse it drives the host start signal and samples the 40-bit sensor frame.
//  It then returns humidity/temperature bytes plus status to conexao_sensor.
//  Owns the tri-state transmission_line; no other block drives it.
// PARAMETERS
//  CLK_FREQ_HZ     50_000_000  system clock frequency; sets the 1 us tick divider
//  START_LOW_US    19000       host start pulse low time, us
//  BIT1_THRESH_US  48          high-phase length (us) above which a bit decodes as 1
//  TIMEOUT_US      200         maximum us in any wait/measure phase before error
// PORTS
//  clock              in     1   system clock, rising edge
//  reset_n            in     1   asynchronous active-low reset
//  start              in     1   1-cycle request pulse from conexao_sensor
//  transmission_line  inout  1   DHT11 data wire; driven 0 or released to Z, never 1
//  busy               out    1   high from accepted start until done asserts
//  done               out    1   1-cycle pulse: frame finished (success or error)
//  error              out    1   valid with done; 1 = frame failed
//  error_code         out    2   00 ok, 01 no response, 10 bit timeout, 11 checksum
//  humidity_int       out    8   byte 0 of frame
//  humidity_dec       out    8   byte 1
//  temperature_int    out    8   byte 2
//  temperature_dec    out    8   byte 3
// BEHAVIOUR
//  - Reset: line released (Z); busy=0, done=0, error=0, error_code=00, data bytes=0, FSM=IDLE.
//  - Reset mid-frame: line released immediately (async); no done pulse is produced.
//  - Line input passes a 2-FF synchronizer; all decisions use the synchronized value.
//  - A 1 us tick comes from a counter wrapping at CLK_FREQ_HZ/1_000_000-1.
//  - A 16-bit us counter clears on every state change; it saturates, never wraps.
//  - FSM:
//    - IDLE: start=1 -> START_LOW, busy=1. start while busy is ignored.
//    - START_LOW: drive 0 for START_LOW_US -> RELEASE.
//    - RELEASE: Z; line low -> RESP_LOW; TIMEOUT_US elapsed -> ERR (01).
//    - RESP_LOW: line high -> RESP_HIGH; timeout -> ERR (01).
//    - RESP_HIGH: line low -> BIT_LOW with bit index 0; timeout -> ERR (01).
//    - BIT_LOW: line high -> BIT_HIGH; timeout -> ERR (10).
//    - BIT_HIGH: on line low, shift bit in MSB-first (1 if count > BIT1_THRESH_US).
//      - Index 39 -> CHECK; otherwise -> BIT_LOW. Timeout -> ERR (10).
//    - CHECK: 1 cycle. Update output bytes. Then done=1, busy=0, -> IDLE.
//    - ERR: 1 cycle. done=1, error=1, error_code set, busy=0, output bytes unchanged, -> IDLE.
//  - Data bytes change only in CHECK; they hold their value until the next successful frame.
//  - error/error_code hold until the next accepted start, which clears them.
//  - Latency from start to done: about 19 ms + 4.1-5.4 ms sensor frame.
//  - Minimum restart interval is not enforced here; conexao_sensor spaces requests at 2 s or more.
// CONFIGURATION
//  DHT11_CHECKSUM_EN defined:
//   - CHECK compares byte4 against (byte0+byte1+byte2+byte3) mod 256.
//   - Mismatch -> error=1, code 11, output bytes unchanged.
//  DHT11_CHECKSUM_EN undefined:
//   - byte4 is discarded; CHECK always succeeds and code 11 never occurs.
// TESTING
//  1. Sensor model sends 0x37,0x00,0x19,0x00,0x50 -> done with error=0; hum_int=55, temp_int=25.
//  2. No sensor response after release -> done after about 19.2 ms with error=1, code 01; line Z.
//  3. Sensor stops after bit 17 -> done TIMEOUT_US later with error=1, code 10; bytes keep prior values.
//  4. Frame 0x37,0x00,0x19,0x00,0x51 with DHT11_CHECKSUM_EN -> code 11. Without it -> ok, hum_int=55.
//  5. start re-pulsed during BIT_HIGH, and reset_n low mid-frame:
//     - Re-pulse: ignored.
//     - Reset: line Z that cycle; busy=0; no done.
//  6. Bit high times 27 us and 70 us; threshold edge at 48 us vs 49 us -> bits decode 0, 1, 0, 1.

Source files
------------

// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: start pulse, response handshake, 40-bit capture, byte/status report.
// Optional build macro DHT11_CHECKSUM_EN enables byte-4 checksum verification.
module dht11_reader #(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int START_LOW_US   = 19000,
  parameter int BIT1_THRESH_US = 48,
  parameter int TIMEOUT_US     = 200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  inout  wire        transmission_line,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] error_code,
  output logic [7:0] humidity_int,
  output logic [7:0] humidity_dec,
  output logic [7:0] temperature_int,
  output logic [7:0] temperature_dec
);

  localparam logic [15:0] DIV_M1    = 16'(CLK_FREQ_HZ / 1_000_000 - 1);
  localparam logic [15:0] START_LOW = 16'(START_LOW_US);
  localparam logic [15:0] TOUT      = 16'(TIMEOUT_US);
  localparam logic [16:0] THRESH    = 17'(BIT1_THRESH_US);
`ifdef DHT11_CHECKSUM_EN
  localparam int SHW = 40;
`else
  localparam int SHW = 32;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      div_q, div_d;
  logic [15:0]      us_q, us_d;
  logic [1:0]       sync_q;
  logic [5:0]       idx_q, idx_d;
  logic [SHW-1:0]   shreg_q, shreg_d;
  logic [1:0]       pend_q, pend_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [1:0]       code_q, code_d;
  logic [7:0]       hi_q, hi_d, hd_q, hd_d, ti_q, ti_d, td_q, td_d;

  logic             tick, line_s, timeout, bit_val, ck_ok;
  logic [16:0]      meas;

  assign tick    = (div_q == DIV_M1);
  assign line_s  = sync_q[1];
  assign timeout = (us_q >= TOUT);
  // Count the tick landing on the sampling edge so an N-us high phase measures exactly N.
  assign meas    = {1'b0, us_q} + {16'd0, tick};
  assign bit_val = (meas > THRESH);

`ifdef DHT11_CHECKSUM_EN
  logic [7:0] ck_sum;
  assign ck_sum = shreg_q[39:32] + shreg_q[31:24] + shreg_q[23:16] + shreg_q[15:8];
  assign ck_ok  = (ck_sum == shreg_q[7:0]);
`else
  assign ck_ok  = 1'b1;
`endif

  assign transmission_line = (state_q == S_START_LOW) ? 1'b0 : 1'bz;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    code_d  = code_q;
    hi_d    = hi_q;
    hd_d    = hd_q;
    ti_d    = ti_q;
    td_d    = td_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START_LOW;
          busy_d  = 1'b1;
          error_d = 1'b0;
          code_d  = 2'b00;
        end
      end
      S_START_LOW: begin
        if (us_q >= START_LOW) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // The synchronizer still holds our own drive-low for a few cycles after release.
        if (!line_s && us_q >= 16'd2) begin
          state_d = S_RESP_LOW;
        end else if (timeout) begin
          state_d = S_ERR;
          pend_d  = 2'b01;
        end
      end
      S_RESP_LOW: begin
        if (line_s) state_d = S_RESP_HIGH;
        else if (timeout) begin
          state_d = S_ERR;
          pend_d  = 2'b01;
        end
      end
      S_RESP_HIGH: begin
        if (!line_s) begin
          state_d = S_BIT_LOW;
          idx_d   = 6'd0;
        end else if (timeout) begin
          state_d = S_ERR;
          pend_d  = 2'b01;
        end
      end
      S_BIT_LOW: begin
        if (line_s) state_d = S_BIT_HIGH;
        else if (timeout) begin
          state_d = S_ERR;
          pend_d  = 2'b10;
        end
      end
      S_BIT_HIGH: begin
        if (!line_s) begin
          if (idx_q < 6'(SHW)) shreg_d = {shreg_q[SHW-2:0], bit_val};
          if (idx_q == 6'd39) begin
            state_d = S_CHECK;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_BIT_LOW;
          end
        end else if (timeout) begin
          state_d = S_ERR;
          pend_d  = 2'b10;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (ck_ok) begin
          hi_d = shreg_q[SHW-1  -: 8];
          hd_d = shreg_q[SHW-9  -: 8];
          ti_d = shreg_q[SHW-17 -: 8];
          td_d = shreg_q[SHW-25 -: 8];
        end else begin
          error_d = 1'b1;
          code_d  = 2'b11;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        error_d = 1'b1;
        code_d  = pend_q;
      end
      default: state_d = S_IDLE;
    endcase

    div_d = tick ? 16'd0 : div_q + 16'd1;
    if (state_d != state_q)             us_d = 16'd0;
    else if (tick && us_q != 16'hFFFF)  us_d = us_q + 16'd1;
    else                                us_d = us_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      us_q    <= '0;
      sync_q  <= 2'b11;
      idx_q   <= '0;
      shreg_q <= '0;
      pend_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= 2'b00;
      hi_q    <= '0;
      hd_q    <= '0;
      ti_q    <= '0;
      td_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      us_q    <= us_d;
      sync_q  <= {sync_q[0], transmission_line};
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
      hi_q    <= hi_d;
      hd_q    <= hd_d;
      ti_q    <= ti_d;
      td_q    <= td_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign error_code      = code_q;
  assign humidity_int    = hi_q;
  assign humidity_dec    = hd_q;
  assign temperature_int = ti_q;
  assign temperature_dec = td_q;

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: behavioural DHT11 sensor driving randomized bit timings, outputs checked against a byte-level model.
module tb_dht11_reader;

  localparam int START_LOW_US = 100;
  localparam int TIMEOUT_US   = 200;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n, start, sensor_low;
  wire        line;
  logic       busy, done, error;
  logic [1:0] error_code;
  logic [7:0] humidity_int, humidity_dec, temperature_int, temperature_dec;

  pullup (line);
  assign line = sensor_low ? 1'b0 : 1'bz;

  dht11_reader #(
    .CLK_FREQ_HZ(2_000_000), .START_LOW_US(START_LOW_US),
    .BIT1_THRESH_US(48), .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .transmission_line(line),
    .busy(busy), .done(done), .error(error), .error_code(error_code),
    .humidity_int(humidity_int), .humidity_dec(humidity_dec),
    .temperature_int(temperature_int), .temperature_dec(temperature_dec)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          done_cnt = 0;
  logic        d_err;
  logic [1:0]  d_code;
  logic [31:0] d_bytes;
  int          d_cyc;
  always @(negedge clock) begin
    if (done === 1'b1) begin
      d_err   = error;
      d_code  = error_code;
      d_bytes = {humidity_int, humidity_dec, temperature_int, temperature_dec};
      d_cyc   = cyc;
      done_cnt++;
    end
  end

  int checks = 0, errors = 0;
  int hi_us[40];
  logic [7:0] fb[5];
  logic [7:0] exp_b[4];
  logic       exp_err;
  logic [1:0] exp_code;
  int t_start, t_rise;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_line(input logic val, input int maxc, input string tag);
    int n = 0;
    while (line !== val && n < maxc) begin
      @(negedge clock);
      n++;
    end
    check(tag, 64'(line === val), 64'd1);
  endtask

  task automatic wait_done(input int prev, input int maxc, input string tag);
    int n = 0;
    while (done_cnt == prev && n < maxc) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done"}, 64'(done_cnt - prev), 64'd1);
  endtask

  // Timing for each data bit from the frame value; a 1 gets a long high phase.
  task automatic make_frame(input logic [39:0] f, input bit thresh);
    logic [7:0] s;
    for (int i = 0; i < 40; i++)
      hi_us[i] = f[39-i] ? int'($urandom_range(60, 75)) : int'($urandom_range(22, 35));
    if (thresh) begin
      hi_us[0] = 27; hi_us[1] = 70; hi_us[2] = 48; hi_us[3] = 49;
    end
    for (int b = 0; b < 5; b++) begin
      fb[b] = 8'd0;
      for (int k = 0; k < 8; k++) fb[b] = {fb[b][6:0], hi_us[8*b+k] > 48};
    end
    if (thresh) begin
      s = fb[0] + fb[1] + fb[2] + fb[3];
      for (int k = 0; k < 8; k++)
        hi_us[32+k] = s[7-k] ? int'($urandom_range(60, 75)) : int'($urandom_range(22, 35));
      fb[4] = s;
    end
  endtask

  task automatic predict();
    bit bad = 1'b0;
`ifdef DHT11_CHECKSUM_EN
    logic [7:0] s;
    s = fb[0] + fb[1] + fb[2] + fb[3];
    bad = (s != fb[4]);
`endif
    if (bad) begin
      exp_err = 1'b1; exp_code = 2'b11;
    end else begin
      exp_err = 1'b0; exp_code = 2'b00;
      for (int b = 0; b < 4; b++) exp_b[b] = fb[b];
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, "_err"},  64'(d_err), 64'(exp_err));
    check({tag, "_code"}, 64'(d_code), 64'(exp_code));
    check({tag, "_bytes"}, 64'(d_bytes), 64'({exp_b[0], exp_b[1], exp_b[2], exp_b[3]}));
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    t_start = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Sensor side: nbits < 40 abandons the frame after releasing the line for that bit.
  task automatic sensor_run(input int nbits, input int repulse_bit, input string tag);
    wait_line(1'b0, 20, {tag, "_hostlow"});
    wait_line(1'b1, 2 * START_LOW_US + 40, {tag, "_release"});
    wait_cyc(40);
    sensor_low = 1'b1; wait_cyc(160);
    sensor_low = 1'b0; wait_cyc(160);
    for (int i = 0; i < nbits; i++) begin
      sensor_low = 1'b1; wait_cyc(40);
      sensor_low = 1'b0;
      t_rise = cyc;
      if (i == repulse_bit) begin
        wait_cyc(20);
        start = 1'b1; wait_cyc(1); start = 1'b0;
        wait_cyc(2 * hi_us[i] - 21);
      end else if (i != nbits - 1 || nbits == 40) begin
        wait_cyc(2 * hi_us[i]);
      end
    end
    if (nbits == 40) begin
      sensor_low = 1'b1; wait_cyc(40);
      sensor_low = 1'b0;
    end
  endtask

  initial begin
    int prev;
    int el;
    logic [31:0] data;
    reset_n = 1'b0; start = 1'b0; sensor_low = 1'b0;
    wait_cyc(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_code", 64'(error_code), 64'd0);
    check("rst_bytes", 64'({humidity_int, humidity_dec, temperature_int, temperature_dec}), 64'd0);
    check("rst_line", 64'(line), 64'd1);
    for (int b = 0; b < 4; b++) exp_b[b] = 8'd0;
    reset_n = 1'b1;
    wait_cyc(3);

    // Reference frame from the datasheet example.
    make_frame(40'h37_00_19_00_50, 1'b0);
    prev = done_cnt;
    pulse_start();
    check("A_busy", 64'(busy), 64'd1);
    check("A_drive", 64'(line), 64'd0);
    sensor_run(40, -1, "A");
    wait_done(prev, 200, "A");
    predict();
    check_out("A");
    check("A_hum55", 64'(d_bytes[31:24]), 64'd55);
    check("A_tmp25", 64'(d_bytes[15:8]), 64'd25);

    // Threshold edge: 27/70/48/49 us decode as 0/1/0/1.
    make_frame({$urandom(), 8'h00}, 1'b1);
    prev = done_cnt;
    pulse_start();
    sensor_run(40, -1, "T");
    wait_done(prev, 200, "T");
    predict();
    check_out("T");
    check("T_edge", 64'(d_bytes[31:28]), 64'h5);

    // Random valid frame with start re-pulsed during a high phase.
    data = $urandom();
    make_frame({data, 8'(data[31:24] + data[23:16] + data[15:8] + data[7:0])}, 1'b0);
    prev = done_cnt;
    pulse_start();
    sensor_run(40, 5, "R");
    wait_done(prev, 200, "R");
    predict();
    check_out("R");
    wait_cyc(200);
    check("R_onedone", 64'(done_cnt - prev), 64'd1);

    // Bad checksum byte.
    make_frame(40'h37_00_19_00_51, 1'b0);
    prev = done_cnt;
    pulse_start();
    sensor_run(40, -1, "C");
    wait_done(prev, 200, "C");
    predict();
    check_out("C");

    // No sensor at all.
    prev = done_cnt;
    pulse_start();
    wait_done(prev, 2000, "N");
    exp_err = 1'b1; exp_code = 2'b01;
    check_out("N");
    el = d_cyc - t_start;
    check("N_time", 64'(el >= 2 * (START_LOW_US + TIMEOUT_US) - 5 && el <= 2 * (START_LOW_US + TIMEOUT_US) + 15), 64'd1);
    check("N_line", 64'(line), 64'd1);

    // Sensor abandons the frame during bit 17; accepted start first clears the old error.
    make_frame({$urandom(), 8'h00}, 1'b0);
    prev = done_cnt;
    pulse_start();
    check("S_errclr", 64'({error, error_code}), 64'd0);
    sensor_run(18, -1, "S");
    wait_done(prev, 1000, "S");
    exp_err = 1'b1; exp_code = 2'b10;
    check_out("S");
    el = d_cyc - t_rise;
    check("S_time", 64'(el >= 2 * TIMEOUT_US - 2 && el <= 2 * TIMEOUT_US + 15), 64'd1);

    // Reset while the host is driving its start pulse.
    prev = done_cnt;
    pulse_start();
    wait_cyc(50);
    check("X_drive", 64'(line), 64'd0);
    reset_n = 1'b0;
    #1;
    check("X_line", 64'(line), 64'd1);
    check("X_busy", 64'(busy), 64'd0);
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(700);
    check("X_nodone", 64'(done_cnt - prev), 64'd0);
    check("X_bytes", 64'({humidity_int, humidity_dec, temperature_int, temperature_dec}), 64'd0);
    check("X_err", 64'({error, error_code}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
